alu_cmd_sequencer: RTL and testbench
====================================

# alu_cmd_sequencer

Command-side front end for the 8-bit combinational ALU: accepts accumulator-style commands over a valid/ready handshake, drives the ALU operand and opcode inputs from registers, and captures the ALU result and flags one cycle later. It returns each result on a valid/ready response channel. It sits between a host (switch/button controller or test harness) and the ALU, which is instantiated alongside it and wired port-to-port.

## Interface
- No parameters; datapath fixed at 8 bits, opcode at 4 bits.
- clk  in  1  system clock, rising edge
- rst_n  in  1  asynchronous, active-low reset
- cmd_valid  in  1  command present
- cmd_ready  out  1  sequencer can accept a command
- cmd_op  in  4  command opcode
- cmd_operand  in  8  B operand / load value
- alu_a  out  8  to ALU A (accumulator)
- alu_b  out  8  to ALU B (registered operand)
- alu_opcode  out  4  to ALU opcode
- alu_result  in  8  from ALU result
- alu_zero  in  1  from ALU zero flag
- alu_carry  in  1  from ALU carry flag
- rsp_valid  out  1  response present
- rsp_ready  in  1  host accepts response
- rsp_data  out  8  accumulator after command
- rsp_zero  out  1  rsp_data == 0
- rsp_carry  out  1  carry/borrow from arithmetic ops, else 0
- rsp_err  out  1  command rejected, accumulator unchanged

## Operation
- States: IDLE, EXEC, RESP. cmd_ready = 1 only in IDLE (registered).
- IDLE: on cmd_valid && cmd_ready, latch cmd_op/cmd_operand into alu_opcode/alu_b and go to EXEC.
- EXEC (exactly one cycle): alu_a = acc; at the closing edge:
  - 0000 ADD, 0001 SUB, 0011 DIV: acc <= alu_result, rsp_carry <= alu_carry.
  - 0100 EQ, 0101 XOR, 0110 XNOR, 0111 AND: acc <= alu_result, rsp_carry <= 0.
  - 1000 LOAD: acc <= operand (ALU output ignored).
  - 1001 CLEAR: acc <= 0.
  - 0011 with operand 0x00: rsp_err <= 1, acc unchanged, carry 0.
  - 0010 and 1010–1111: rsp_err <= 1, acc unchanged, carry 0.
  - rsp_zero <= (new acc == 0). Computed locally, not taken from alu_zero.
  - Then go to RESP.
- RESP: rsp_valid = 1, and rsp_* hold stable until rsp_ready. On rsp_valid && rsp_ready, go to IDLE.
- alu_a/alu_b/alu_opcode hold their last values outside EXEC and are never X. Reset drives opcode 0000.
- Arithmetic wraps modulo 256. SUB borrow is reported as alu_carry unmodified.

## Timing
- Reset (async assert): state IDLE, acc 0, cmd_ready 0, rsp_valid 0, rsp_data 0, rsp_zero 0, rsp_carry 0, rsp_err 0, alu_a 0, alu_b 0, alu_opcode 0.
- cmd_ready rises at the first clk edge after rst_n deasserts.
- Command accepted at edge N: EXEC during cycle N+1, rsp_valid high after edge N+1.
- If rsp_ready is already high, rsp_valid drops and cmd_ready rises after edge N+2. Throughput is 1 command per 3 cycles.
- cmd_valid while not ready is ignored; the host must hold it.
- rst_n asserted mid-EXEC or mid-RESP aborts the command with no response, and acc clears.

## Configuration
- `ALU_CMD_SEQUENCER_OPCOUNT_EN` defined: adds output op_count [15:0], reset 0.
  - Increments at every EXEC exit with rsp_err == 0.
  - Saturates at 0xFFFF.
- Undefined: port and counter are absent. All other behaviour is identical.

## Test plan
- Reset, then LOAD 0x05, ADD 0x03 -> responses rsp_data 0x05 then 0x08. Zero 0, carry 0, err 0.
- LOAD 0xFF, ADD 0x01 -> rsp_data 0x00, rsp_zero 1, rsp_carry 1.
- LOAD 0x10, DIV 0x00 -> rsp_err 1, rsp_data 0x10. Then op 0010 -> rsp_err 1, rsp_data 0x10.
- LOAD 0xA5, XOR 0xFF -> 0x5A with carry 0. Then CLEAR -> 0x00 with zero 1.
- Hold rsp_ready low 5 cycles after a response -> rsp_* stable, cmd_ready 0 throughout. Release -> next command accepted 1 cycle later.
- Assert rst_n low during EXEC of ADD -> all outputs at reset values immediately, and no rsp_valid. With `ALU_CMD_SEQUENCER_OPCOUNT_EN`: op_count counts only non-error commands.

Source files
------------

// File: rtl/alu_cmd_sequencer.sv
// alu_cmd_sequencer: accumulator command front end for the 8-bit ALU, valid/ready in and out.
// Optional op_count output when ALU_CMD_SEQUENCER_OPCOUNT_EN is defined.
module alu_cmd_sequencer (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        cmd_valid,
  output logic        cmd_ready,
  input  logic [3:0]  cmd_op,
  input  logic [7:0]  cmd_operand,
  output logic [7:0]  alu_a,
  output logic [7:0]  alu_b,
  output logic [3:0]  alu_opcode,
  input  logic [7:0]  alu_result,
  input  logic        alu_zero,
  input  logic        alu_carry,
  output logic        rsp_valid,
  input  logic        rsp_ready,
  output logic [7:0]  rsp_data,
  output logic        rsp_zero,
  output logic        rsp_carry,
`ifdef ALU_CMD_SEQUENCER_OPCOUNT_EN
  output logic [15:0] op_count,
`endif
  output logic        rsp_err
);
  typedef enum logic [1:0] {IDLE, EXEC, RESP} state_t;
  state_t state;
  logic [7:0] acc, nxt_acc;
  logic err, arith;
  logic unused_zero;
  assign unused_zero = alu_zero;
  assign alu_a = acc;
  always_comb begin
    err = alu_opcode == 4'h2 || alu_opcode >= 4'hA || (alu_opcode == 4'h3 && alu_b == 8'h00);
    arith = alu_opcode == 4'h0 || alu_opcode == 4'h1 || alu_opcode == 4'h3;
    nxt_acc = err ? acc : alu_opcode == 4'h8 ? alu_b : alu_opcode == 4'h9 ? 8'h00 : alu_result;
  end
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= IDLE;
      acc <= 8'h00;
      cmd_ready <= 1'b0;
      rsp_valid <= 1'b0;
      rsp_data <= 8'h00;
      rsp_zero <= 1'b0;
      rsp_carry <= 1'b0;
      rsp_err <= 1'b0;
      alu_b <= 8'h00;
      alu_opcode <= 4'h0;
    end else begin
      case (state)
        IDLE: begin
          cmd_ready <= 1'b1;
          if (cmd_valid && cmd_ready) begin
            cmd_ready <= 1'b0;
            alu_opcode <= cmd_op;
            alu_b <= cmd_operand;
            state <= EXEC;
          end
        end
        EXEC: begin
          acc <= nxt_acc;
          rsp_data <= nxt_acc;
          rsp_zero <= nxt_acc == 8'h00;
          rsp_carry <= !err && arith && alu_carry;
          rsp_err <= err;
          rsp_valid <= 1'b1;
          state <= RESP;
        end
        default: begin
          if (rsp_ready) begin
            rsp_valid <= 1'b0;
            cmd_ready <= 1'b1;
            state <= IDLE;
          end
        end
      endcase
    end
  end
`ifdef ALU_CMD_SEQUENCER_OPCOUNT_EN
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) op_count <= 16'h0000;
    else if (state == EXEC && !err && op_count != 16'hFFFF) op_count <= op_count + 16'h0001;
  end
`endif
endmodule

// File: tb/tb_alu_cmd_sequencer.sv
// tb_alu_cmd_sequencer: scoreboard bench with a behavioural ALU wired to the sequencer.
module tb_alu_cmd_sequencer;
  logic clk = 1'b0, rst_n = 1'b0, cmd_valid = 1'b0, rsp_ready = 1'b1;
  logic [3:0] cmd_op = 4'h0;
  logic [7:0] cmd_operand = 8'h00;
  logic cmd_ready, rsp_valid, rsp_zero, rsp_carry, rsp_err, alu_zero, alu_carry;
  logic [7:0] alu_a, alu_b, alu_result, rsp_data;
  logic [3:0] alu_opcode;
`ifdef ALU_CMD_SEQUENCER_OPCOUNT_EN
  logic [15:0] op_count;
  int exp_cnt = 0;
`endif
  typedef struct {logic [7:0] d; logic z, c, e;} rsp_t;
  rsp_t q[$];
  int n_cmp = 0, n_fail = 0;

  always #5 clk = ~clk;

  alu_cmd_sequencer dut (
    .clk(clk), .rst_n(rst_n), .cmd_valid(cmd_valid), .cmd_ready(cmd_ready),
    .cmd_op(cmd_op), .cmd_operand(cmd_operand), .alu_a(alu_a), .alu_b(alu_b),
    .alu_opcode(alu_opcode), .alu_result(alu_result), .alu_zero(alu_zero),
    .alu_carry(alu_carry), .rsp_valid(rsp_valid), .rsp_ready(rsp_ready),
    .rsp_data(rsp_data), .rsp_zero(rsp_zero), .rsp_carry(rsp_carry),
`ifdef ALU_CMD_SEQUENCER_OPCOUNT_EN
    .op_count(op_count),
`endif
    .rsp_err(rsp_err)
  );

  always_comb begin
    logic [8:0] t;
    t = 9'h000;
    case (alu_opcode)
      4'h0: t = {1'b0, alu_a} + {1'b0, alu_b};
      4'h1: t = {1'b0, alu_a} - {1'b0, alu_b};
      4'h3: t = {1'b0, alu_b == 8'h00 ? 8'h00 : alu_a / alu_b};
      4'h4: t = {8'h00, alu_a == alu_b};
      4'h5: t = {1'b0, alu_a ^ alu_b};
      4'h6: t = {1'b0, ~(alu_a ^ alu_b)};
      4'h7: t = {1'b0, alu_a & alu_b};
      default: t = 9'h000;
    endcase
    alu_result = t[7:0];
    alu_carry = t[8];
    alu_zero = t[7:0] == 8'h00;
  end

  task automatic check(input string name, input int act, input int exp);
    n_cmp++;
    if (act != exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
    end
  endtask

  always @(negedge clk) begin
    if (rsp_valid && rsp_ready) begin
      if (q.size() == 0) check("unexpected_rsp", 1, 0);
      else begin
        rsp_t r;
        r = q.pop_front();
        check("rsp_data", rsp_data, r.d);
        check("rsp_zero", rsp_zero, r.z);
        check("rsp_carry", rsp_carry, r.c);
        check("rsp_err", rsp_err, r.e);
      end
    end
  end

  task automatic send(input logic [3:0] op, input logic [7:0] b, input bit chk,
                      input logic [7:0] d, input logic z, input logic c, input logic e);
    int t;
    t = 0;
    @(negedge clk);
    while (!cmd_ready && t < 50) begin
      @(negedge clk);
      t++;
    end
    if (!cmd_ready) check("cmd_ready_timeout", 0, 1);
    else begin
      cmd_valid = 1'b1;
      cmd_op = op;
      cmd_operand = b;
      if (chk) begin
        q.push_back('{d, z, c, e});
`ifdef ALU_CMD_SEQUENCER_OPCOUNT_EN
        if (!e) exp_cnt++;
`endif
      end
      @(posedge clk);
      #1 cmd_valid = 1'b0;
    end
  endtask

  task automatic drain();
    int t;
    t = 0;
    while (q.size() != 0 && t < 50) begin
      @(negedge clk);
      t++;
    end
    check("drain_timeout", q.size(), 0);
  endtask

  initial begin
    #12;
    check("rst_cmd_ready", cmd_ready, 0);
    check("rst_rsp_valid", rsp_valid, 0);
    check("rst_rsp_data", rsp_data, 0);
    check("rst_alu_a", alu_a, 0);
    check("rst_alu_b", alu_b, 0);
    check("rst_alu_opcode", alu_opcode, 0);
    @(negedge clk);
    rst_n = 1'b1;
    #1 check("cmd_ready_before_edge", cmd_ready, 0);
    @(posedge clk);
    #1 check("cmd_ready_after_edge", cmd_ready, 1);
    send(4'h8, 8'h05, 1, 8'h05, 0, 0, 0);
    send(4'h0, 8'h03, 1, 8'h08, 0, 0, 0);
    send(4'h8, 8'hFF, 1, 8'hFF, 0, 0, 0);
    send(4'h0, 8'h01, 1, 8'h00, 1, 1, 0);
    send(4'h8, 8'h10, 1, 8'h10, 0, 0, 0);
    send(4'h3, 8'h00, 1, 8'h10, 0, 0, 1);
    send(4'h2, 8'h22, 1, 8'h10, 0, 0, 1);
    send(4'h8, 8'hA5, 1, 8'hA5, 0, 0, 0);
    send(4'h5, 8'hFF, 1, 8'h5A, 0, 0, 0);
    send(4'h9, 8'h77, 1, 8'h00, 1, 0, 0);
    send(4'h8, 8'h03, 1, 8'h03, 0, 0, 0);
    send(4'h1, 8'h05, 1, 8'hFE, 0, 1, 0);
    send(4'h8, 8'h64, 1, 8'h64, 0, 0, 0);
    send(4'h3, 8'h07, 1, 8'h0E, 0, 0, 0);
    send(4'h7, 8'h0B, 1, 8'h0A, 0, 0, 0);
    send(4'hF, 8'h01, 1, 8'h0A, 0, 0, 1);
    send(4'h4, 8'h0A, 1, 8'h01, 0, 0, 0);
    send(4'h6, 8'hFE, 1, 8'h00, 1, 0, 0);
    drain();
    rsp_ready = 1'b0;
    send(4'h8, 8'h33, 1, 8'h33, 0, 0, 0);
    begin
      int t;
      t = 0;
      while (!rsp_valid && t < 20) begin
        @(negedge clk);
        t++;
      end
    end
    check("stall_rsp_valid", rsp_valid, 1);
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      check("stall_valid", rsp_valid, 1);
      check("stall_data", rsp_data, 8'h33);
      check("stall_err", rsp_err, 0);
      check("stall_cmd_ready", cmd_ready, 0);
    end
    @(posedge clk);
    #1 rsp_ready = 1'b1;
    @(posedge clk);
    #1 check("release_cmd_ready", cmd_ready, 1);
    check("release_rsp_valid", rsp_valid, 0);
    drain();
    send(4'h0, 8'h01, 0, 8'h00, 0, 0, 0);
    #1 rst_n = 1'b0;
    #1;
    check("abort_rsp_valid", rsp_valid, 0);
    check("abort_cmd_ready", cmd_ready, 0);
    check("abort_rsp_data", rsp_data, 0);
    check("abort_rsp_carry", rsp_carry, 0);
    check("abort_alu_a", alu_a, 0);
    check("abort_alu_b", alu_b, 0);
    check("abort_alu_opcode", alu_opcode, 0);
`ifdef ALU_CMD_SEQUENCER_OPCOUNT_EN
    check("abort_op_count", op_count, 0);
    exp_cnt = 0;
`endif
    repeat (2) @(negedge clk);
    check("abort_no_rsp", rsp_valid, 0);
    rst_n = 1'b1;
    send(4'h0, 8'h07, 1, 8'h07, 0, 0, 0);
    send(4'h3, 8'h00, 1, 8'h07, 0, 0, 1);
    send(4'h1, 8'h08, 1, 8'hFF, 0, 1, 0);
    drain();
`ifdef ALU_CMD_SEQUENCER_OPCOUNT_EN
    check("op_count", op_count, exp_cnt);
`endif
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end
endmodule
